dwnsmp_phase_sel: RTL

- Upstream neighbour of the slicer.
- Takes the matched-filter output at OS samples per symbol and keeps one sample per symbol, at the selected phase.
- Emits that sample plus a one-cycle symbol strobe, which feed the slicer's i_dwnsmp and i_sync.
- The phase is either set from a control input or picked by a max-energy estimator that runs over a window of symbols.

---
 rtl/dwnsmp_phase_sel.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dwnsmp_phase_sel.sv
// Symbol-rate decimator with selectable sampling phase.
// Keeps one of every OS matched-filter samples, at either a manually chosen
// phase or the phase with the largest accumulated magnitude over a window of
// 2^LOG_WIN symbols. Emits the kept sample with a one-cycle strobe.
//
// Handshake: a sample is consumed on any rising edge where i_enable and
// i_valid are both high; there is no back-pressure. o_sync is high for exactly
// one clock after each kept sample, and o_dwnsmp holds its value between strobes.
module dwnsmp_phase_sel #(
    parameter int OS      = 4,
    parameter int NB_PH   = 2,
    parameter int NB_DATA = 10,
    parameter int LOG_WIN = 4
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_valid,
    input  logic signed [NB_DATA-1:0] i_sample,
    input  logic        [NB_PH-1:0]   i_phase,
    input  logic                      i_auto,
    output logic signed [NB_DATA-1:0] o_dwnsmp,
    output logic                      o_sync,
    output logic        [NB_PH-1:0]   o_phase
);

    localparam int NB_ACC = NB_DATA + LOG_WIN;

    logic [NB_PH-1:0]   r_cnt;
    logic [NB_PH-1:0]   r_sel_phase;
    logic [NB_PH-1:0]   r_est_phase;
    logic [LOG_WIN-1:0] r_sym_cnt;
    logic [NB_ACC-1:0]  r_acc [OS];

    logic               w_adv;
    logic               w_boundary;
    logic               w_win_end;
    logic [NB_DATA-1:0] w_abs;
    logic [NB_ACC-1:0]  w_acc_next [OS];
    logic [NB_ACC-1:0]  w_best_val;
    logic [NB_PH-1:0]   w_best_idx;
    logic [NB_PH-1:0]   w_new_phase;

    // Qualifier, symbol boundary, magnitude, and next accumulator values.
    always_comb begin
        w_adv       = i_enable & i_valid;
        w_boundary  = w_adv & (r_cnt == NB_PH'(OS - 1));
        w_win_end   = w_boundary & (r_sym_cnt == {LOG_WIN{1'b1}});
        // Two's-complement negate read as unsigned: the most negative input
        // maps onto 2^(NB_DATA-1) exactly.
        w_abs       = i_sample[NB_DATA-1] ? ($unsigned(~i_sample) + 1'b1)
                                          : $unsigned(i_sample);
        w_new_phase = i_auto ? r_est_phase : i_phase;
        for (int k = 0; k < OS; k++) begin
            w_acc_next[k] = r_acc[k];
            if (w_adv && (r_cnt == NB_PH'(k))) begin
                w_acc_next[k] = r_acc[k] + NB_ACC'(w_abs);
            end
        end
    end

    // Argmax over the closing window; strict compare keeps the lowest index on ties.
    always_comb begin
        w_best_val = w_acc_next[0];
        w_best_idx = '0;
        for (int k = 1; k < OS; k++) begin
            if (w_acc_next[k] > w_best_val) begin
                w_best_val = w_acc_next[k];
                w_best_idx = NB_PH'(k);
            end
        end
    end

    // Sample counter, phase selection, and symbol counter.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_sel_phase <= '0;
            r_sym_cnt   <= '0;
        end else if (w_adv) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_boundary) begin
                r_sel_phase <= w_new_phase;
                r_sym_cnt   <= r_sym_cnt + 1'b1;
            end
        end
    end

    // Energy accumulators and estimated phase; the window-end sample counts
    // toward the closing window only, then everything clears.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_est_phase <= '0;
            for (int k = 0; k < OS; k++) begin
                r_acc[k] <= '0;
            end
        end else if (w_win_end) begin
            r_est_phase <= w_best_idx;
            for (int k = 0; k < OS; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            for (int k = 0; k < OS; k++) begin
                r_acc[k] <= w_acc_next[k];
            end
        end
    end

    // Decimated output register and strobe; the strobe drops whenever no
    // selected sample is consumed, including while disabled.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_dwnsmp <= '0;
            o_sync   <= 1'b0;
        end else begin
            o_sync <= w_adv & (r_cnt == r_sel_phase);
            if (w_adv && (r_cnt == r_sel_phase)) begin
                o_dwnsmp <= i_sample;
            end
        end
    end

    assign o_phase = r_sel_phase;

endmodule
